// File: rtl/data_ring_writer_pkg.sv
// data_ring_writer_pkg: shared controller state encodings and ring-bound helpers for ring-buffer address generators.
package data_ring_writer_pkg;
    typedef enum logic {SLEEP = 1'b0, RUN = 1'b1} ring_state_t;
    localparam int RING_ADDR_W   = 12;
    localparam int RING_OFFSET_W = 10;
    localparam int RING_SAMPLE_W = 16;
    function automatic logic ring_span_ok(input int unsigned lo, input int unsigned hi, input int unsigned ow);
        return (hi >= lo) && ((hi - lo) < (32'd1 << ow));
    endfunction
endpackage

// File: rtl/ring_addr_next.sv
// ring_addr_next: next ring address, wrapping from hi back to lo.
module ring_addr_next #(
    parameter int W = 12
) (
    input  logic [W-1:0] cur,
    input  logic [W-1:0] lo,
    input  logic [W-1:0] hi,
    output logic [W-1:0] nxt
);
    assign nxt = (cur == hi) ? lo : cur + W'(1);
endmodule

// File: rtl/data_ring_writer.sv
// data_ring_writer: writes an input sample stream into a bounded RAM ring and reports head offset and fill status.
module data_ring_writer
    import data_ring_writer_pkg::*;
#(
    parameter int DATA_ADDRESS_WIDTH = RING_ADDR_W,
    parameter int DATA_OFFSET_WIDTH  = RING_OFFSET_W,
    parameter int SAMPLE_WIDTH       = RING_SAMPLE_W
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic                          init,
    input  logic [DATA_ADDRESS_WIDTH-1:0] data_uptr,
    input  logic [DATA_ADDRESS_WIDTH-1:0] data_lptr,
    input  logic                          in_valid,
    input  logic [SAMPLE_WIDTH-1:0]       in_data,
    output logic                          in_ready,
    input  logic                          lock,
    output logic                          ram_we,
    output logic [DATA_ADDRESS_WIDTH-1:0] ram_waddr,
    output logic [SAMPLE_WIDTH-1:0]       ram_wdata,
    output logic [DATA_OFFSET_WIDTH-1:0]  head_offset,
    output logic                          primed,
    output logic                          cfg_err
);
    localparam int AW = DATA_ADDRESS_WIDTH;
    localparam int OW = DATA_OFFSET_WIDTH;
    localparam int CW = DATA_OFFSET_WIDTH + 1;
    ring_state_t state, state_nx;
    logic [AW-1:0] uptr, lptr, head, head_nx;
    logic [CW-1:0] fill, depth;
    logic init_ok, acc;
    assign init_ok  = ring_span_ok(32'(data_uptr), 32'(data_lptr), 32'(OW));
    assign in_ready = (state == RUN) && !lock && !init;
    assign acc      = in_valid && in_ready;
    // depth = number of slots, fits CW bits since span < 2^OW
    assign depth    = CW'(lptr - uptr) + CW'(1);
    ring_addr_next #(.W(AW)) u_next (.cur(head), .lo(uptr), .hi(lptr), .nxt(head_nx));
    always_comb begin
        state_nx = state;
        if (init) state_nx = init_ok ? RUN : SLEEP;
    end
    always_ff @(posedge clk) begin
        if (clr) begin
            state       <= SLEEP;
            uptr        <= '0;
            lptr        <= '0;
            head        <= '0;
            fill        <= '0;
            ram_we      <= 1'b0;
            ram_waddr   <= '0;
            ram_wdata   <= '0;
            head_offset <= '0;
            primed      <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            state  <= state_nx;
            ram_we <= acc;
            if (init) begin
                fill    <= '0;
                primed  <= 1'b0;
                cfg_err <= !init_ok;
                if (init_ok) begin
                    uptr        <= data_uptr;
                    lptr        <= data_lptr;
                    head        <= data_lptr;
                    head_offset <= OW'(data_lptr - data_uptr);
                end
            end else if (acc) begin
                head        <= head_nx;
                ram_waddr   <= head_nx;
                ram_wdata   <= in_data;
                head_offset <= OW'(head_nx - uptr);
                if (fill != depth) fill <= fill + CW'(1);
                if (fill + CW'(1) == depth) primed <= 1'b1;
            end
        end
    end
endmodule
